alu_issue_ctrl: RTL and testbench

// - Initiator side of the combinational ALU port (func/A/B in, out back): accepts operation requests from decode

---
 rtl/alu_issue_if.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 89 ++++++++
 tb/tb_alu_issue_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode request, ALU drive/return and writeback response bundle for alu_issue_ctrl.
interface alu_issue_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_func;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [5:0]       alu_func;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  modport master (
    input  req_valid, req_func, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_func, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );
  modport slave (
    output req_valid, req_func, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_func, alu_a, alu_b, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-op issue controller between decode, a combinational ALU and writeback.
// Define ALU_DIV0_TRAP_EN to trap DIV by zero without issuing it to the ALU.
module alu_issue_ctrl #(
  parameter int SETTLE = 1,
  parameter int WIDTH  = 32
) (
  input logic         clk,
  input logic         rst,
  alu_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, TRAP, RESP} state_t;
  localparam logic [5:0] OP_DIV   = 6'd3;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE);
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [5:0]       r_func;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;
  logic             r_ready;
  logic             r_busy;
  logic             w_accept;
  logic             w_trap;
  assign w_accept = bus.req_valid & r_ready;
`ifdef ALU_DIV0_TRAP_EN
  assign w_trap = (bus.req_func == OP_DIV) && (bus.req_b == '0);
`else
  assign w_trap = 1'b0;
`endif
  // Counter starts at SETTLE so capture lands SETTLE+1 edges after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_func  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          if (w_trap) r_state <= TRAP;
          else begin
            r_state <= WAIT;
            r_func  <= bus.req_func;
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_cnt   <= CNT_LOAD;
          end
        end
        WAIT: if (r_cnt == '0) begin
          r_data  <= bus.alu_out;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= RESP;
        end else r_cnt <= r_cnt - 4'd1;
        TRAP: begin
          r_data  <= '0;
          r_err   <= 1'b1;
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = r_ready;
  assign bus.alu_func  = r_func;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.rsp_valid = r_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl against a transaction-level model.
module tb_alu_issue_ctrl;
  localparam int W = 32;
  localparam int S = 4;
`ifdef ALU_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  typedef struct {logic [W-1:0] d; logic e;} rsp_t;
  typedef struct {logic [5:0] f; logic [W-1:0] a; logic [W-1:0] b;} op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  rsp_t sb[$];
  op_t ops[$];
  always #5 clk = ~clk;
  alu_issue_if #(.WIDTH(W)) bus();
  alu_issue_ctrl #(.SETTLE(S), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [W-1:0] alu_fn(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
    case (f)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a * b;
      6'd3: return (b == '0) ? '1 : a / b;
      6'd4: return a & b;
      6'd5: return a | b;
      default: return '0;
    endcase
  endfunction
  function automatic bit is_trap(logic [5:0] f, logic [W-1:0] b);
    return TRAP_EN && f == 6'd3 && b == '0;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Behavioural ALU seen by the controller
  always_comb bus.alu_out = alu_fn(bus.alu_func, bus.alu_a, bus.alu_b);
  rsp_t x;
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (bus.req_valid && bus.req_ready)
        sb.push_back(is_trap(bus.req_func, bus.req_b) ? '{d: '0, e: 1'b1}
                     : '{d: alu_fn(bus.req_func, bus.req_a, bus.req_b), e: 1'b0});
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) chk("rsp_spurious", 1, 0);
        else begin
          x = sb.pop_front();
          chk("rsp_data", bus.rsp_data, x.d);
          chk("rsp_err", bus.rsp_err, x.e);
        end
      end
    end
  end
  task automatic single(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b, int hold);
    bit t = is_trap(f, b);
    logic [W-1:0] ed = t ? '0 : alu_fn(f, a, b);
    logic [W-1:0] pa = bus.alu_a;
    int n = 0;
    bus.req_func = f;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    chk("idle_ready", bus.req_ready, 1);
    tick;
    bus.req_valid = 1'b0;
    chk("acc_ready", bus.req_ready, 0);
    chk("acc_busy", bus.busy, 1);
    chk("alu_a", bus.alu_a, t ? pa : a);
    if (!t) chk("alu_b", bus.alu_b, b);
    if (!t) chk("alu_func", bus.alu_func, f);
    while (!bus.rsp_valid && n < 40) begin
      tick;
      n++;
    end
    chk("latency", n, t ? 1 : S + 1);
    chk("rise_data", bus.rsp_data, ed);
    chk("rise_err", bus.rsp_err, t);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, ed);
      chk("hold_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick;
    bus.rsp_ready = 1'b0;
    chk("done_valid", bus.rsp_valid, 0);
    chk("done_ready", bus.req_ready, 1);
    chk("done_busy", bus.busy, 0);
  endtask
  task automatic stream(bit rnd);
    int idx = 0;
    int guard = 0;
    int start = n_rsp;
    bit acc;
    while ((idx < ops.size() || n_rsp - start < ops.size()) && guard < 5000) begin
      bus.rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.req_valid = idx < ops.size();
      if (idx < ops.size()) begin
        bus.req_func = ops[idx].f;
        bus.req_a = ops[idx].a;
        bus.req_b = ops[idx].b;
      end
      acc = bus.req_valid && bus.req_ready;
      tick;
      guard++;
      if (acc) idx++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("stream_rsps", n_rsp - start, ops.size());
    ops.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_func = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_func", bus.alu_func, 0);
    rst = 1'b0;
    tick;
    single(6'd0, 5, 7, 0);
    single(6'd2, 32'h10000, 32'h10000, 0);
    single(6'd1, 3, 5, 10);
    single(6'd3, 9, 0, 0);
    single(6'd3, 100, 7, 1);
    single(6'd7, 1, 2, 0);
    single(6'd3, 9, 0, 2);
    bus.req_func = 6'd0;
    bus.req_a = 32'h11;
    bus.req_b = 32'h22;
    bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.rsp_valid, 0);
    chk("arst_ready", bus.req_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_alu_a", bus.alu_a, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("no_rsp_after_rst", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;
    ops.push_back('{f: 6'd4, a: 32'hF0F0, b: 32'hFF00});
    ops.push_back('{f: 6'd5, a: 32'h1, b: 32'h2});
    stream(1'b0);
    for (int i = 0; i < 60; i++) begin
      op_t o;
      o.f = ($urandom_range(0, 9) > 7) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
      o.a = $urandom;
      o.b = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      ops.push_back(o);
    end
    stream(1'b1);
    tick;
    chk("sb_empty", sb.size(), 0);
    chk("final_idle", bus.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
